// File: rtl/mulc_seq_if.sv
// CPU-side request/response bundle for the mulc_seq multiply sequencer.
interface mulc_seq_if #(
  parameter int unsigned ACC_W = 40
);
  logic             start;
  logic [1:0]       op;
  logic             sgn_a;
  logic             sgn_b;
  logic [31:0]      a_in;
  logic [31:0]      b_in;
  logic             busy;
  logic             done;
  logic [31:0]      res;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  modport master (
    output start, op, sgn_a, sgn_b, a_in, b_in,
    input  busy, done, res, acc, ovf
  );

  modport slave (
    input  start, op, sgn_a, sgn_b, a_in, b_in,
    output busy, done, res, acc, ovf
  );
endinterface

// File: rtl/mulc_seq.sv
// Multiply sequencer feeding the external 17x17 signed multiplier.
// MUL16, MAC16 (40-bit accumulator), 3-pass MUL32L (low word), CLRACC.
// Optional build macro MULC_SAT_EN: saturating MAC16 with sticky ovf;
// without it the accumulator wraps and ovf is tied low.
module mulc_seq #(
  parameter int unsigned ACC_W = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  mulc_seq_if.slave   bus,
  output logic [16:0] mul_a,
  output logic [16:0] mul_b,
  input  logic [33:0] mul_p
);

  typedef enum logic [2:0] {IDLE, EXEC, P1, P2, DONE} state_t;
  typedef enum logic [1:0] {
    OP_MUL16  = 2'b00,
    OP_MAC16  = 2'b01,
    OP_MUL32L = 2'b10,
    OP_CLRACC = 2'b11
  } op_t;

  state_t           state;
  op_t              op_q;
  logic             sgn_a_q;
  logic             sgn_b_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      res_q;
  logic [ACC_W-1:0] acc_q;
  logic             busy_q;
  logic             done_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] mac_next;

  assign prod_ext = {{(ACC_W-34){mul_p[33]}}, mul_p};

`ifdef MULC_SAT_EN
  logic [ACC_W:0] mac_sum;
  logic           mac_ovf;
  logic           ovf_q;

  // Overflow shows as disagreement between the guard bit and the 40-bit sign.
  assign mac_sum  = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign mac_ovf  = mac_sum[ACC_W] ^ mac_sum[ACC_W-1];
  assign mac_next = !mac_ovf        ? mac_sum[ACC_W-1:0] :
                    mac_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};
  assign bus.ovf  = ovf_q;
`else
  assign mac_next = acc_q + prod_ext;
  assign bus.ovf  = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.acc  = acc_q;

  // Multiplier operand select per pass; idle/done and CLRACC drive zero.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      EXEC: begin
        case (op_q)
          OP_MUL16, OP_MAC16: begin
            mul_a = {sgn_a_q & a_q[15], a_q[15:0]};
            mul_b = {sgn_b_q & b_q[15], b_q[15:0]};
          end
          OP_MUL32L: begin
            mul_a = {1'b0, a_q[15:0]};
            mul_b = {1'b0, b_q[15:0]};
          end
          default: ;
        endcase
      end
      P1: begin
        mul_a = {1'b0, a_q[31:16]};
        mul_b = {1'b0, b_q[15:0]};
      end
      P2: begin
        mul_a = {1'b0, a_q[15:0]};
        mul_b = {1'b0, b_q[31:16]};
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered handshake and result/accumulator state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_MUL16;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULC_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q    <= op_t'(bus.op);
            sgn_a_q <= bus.sgn_a;
            sgn_b_q <= bus.sgn_b;
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            busy_q  <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          case (op_q)
            OP_MUL16: res_q <= mul_p[31:0];
            OP_MAC16: begin
              acc_q <= mac_next;
              res_q <= mac_next[31:0];
`ifdef MULC_SAT_EN
              if (mac_ovf) ovf_q <= 1'b1;
`endif
            end
            OP_CLRACC: begin
              acc_q <= '0;
`ifdef MULC_SAT_EN
              ovf_q <= 1'b0;
`endif
            end
            OP_MUL32L: begin
              // EXEC doubles as pass P0 of the three-pass low-word multiply.
              res_q  <= mul_p[31:0];
              state  <= P1;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          endcase
        end
        P1: begin
          res_q <= res_q + {mul_p[15:0], 16'h0000};
          state <= P2;
        end
        P2: begin
          res_q  <= res_q + {mul_p[15:0], 16'h0000};
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
